rans_out_merge: RTL and testbench

Downstream neighbour of rans_multi_stream. It collects the renormalisation words that each rANS encoder lane emits, including each lane's final state-flush words. Each lane's words are buffered in a small per-lane FIFO. A round-robin arbiter merges the lanes into one tagged output word stream with valid/ready flow control, for the DMA/packer. It reports completion once every lane has delivered its last word.

---
 rtl/rans_pkg.sv | 18 +
 rtl/rans_word_fifo.sv | 50 +++++
 rtl/rans_out_merge.sv | 129 ++++++++++++
 tb/tb_rans_out_merge.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rans_pkg.sv
// Shared types for the rANS output path: word, lane tag and the
// {last, word} entry that each lane FIFO stores.
package rans_pkg;

    localparam int DEF_NUM_STREAMS = 4;
    localparam int DEF_WORD_WIDTH  = 8;
    localparam int DEF_FIFO_DEPTH  = 8;
    localparam int DEF_ID_WIDTH    = $clog2(DEF_NUM_STREAMS);

    typedef logic [DEF_WORD_WIDTH-1:0] word_t;
    typedef logic [DEF_ID_WIDTH-1:0]   lane_id_t;

    typedef struct packed {
        logic  last;
        word_t word;
    } fifo_entry_t;

endpackage

// File: rtl/rans_word_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the oldest entry,
// pointers carry one extra wrap bit so full and empty are distinguishable.
module rans_word_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rans_out_merge.sv
// Merges per-lane rANS renormalisation words into one tagged stream via
// per-lane FIFOs and a round-robin arbiter feeding a single output register.
module rans_out_merge
    import rans_pkg::*;
#(
    parameter  int NUM_STREAMS = 4,
    parameter  int WORD_WIDTH  = 8,
    parameter  int FIFO_DEPTH  = 8,
    localparam int ID_WIDTH    = $clog2(NUM_STREAMS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic [NUM_STREAMS-1:0]            in_valid,
    input  logic [NUM_STREAMS*WORD_WIDTH-1:0] in_data,
    input  logic [NUM_STREAMS-1:0]            in_last,
    output logic [NUM_STREAMS-1:0]            in_ready,
    output logic                              out_valid,
    output logic [WORD_WIDTH-1:0]             out_data,
    output logic [ID_WIDTH-1:0]               out_id,
    output logic                              out_last,
    input  logic                              out_ready,
    output logic                              all_done
);

    // Handshakes: a word transfers on a rising edge where valid && ready;
    // valid never depends on ready, and held words stay stable until taken.

    logic [NUM_STREAMS-1:0] fifo_full;
    logic [NUM_STREAMS-1:0] fifo_empty;
    logic [NUM_STREAMS-1:0] fifo_push;
    logic [NUM_STREAMS-1:0] fifo_pop;
    logic [WORD_WIDTH:0]    fifo_dout [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] last_seen;
    logic [NUM_STREAMS-1:0] last_sent;
    logic [NUM_STREAMS-1:0] sent_now;

    logic [ID_WIDTH-1:0]    rr_ptr;
    logic [ID_WIDTH-1:0]    grant_id;
    logic [ID_WIDTH-1:0]    scan_idx;
    logic                   grant_valid;
    logic [WORD_WIDTH:0]    grant_entry;
    logic                   load;
    logic                   out_fire;

    assign load        = !out_valid || out_ready;
    assign out_fire    = out_valid && out_ready;
    assign grant_entry = fifo_dout[grant_id];

    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_lane
        assign in_ready[i]  = !fifo_full[i] && !last_seen[i] && !rst;
        assign fifo_push[i] = in_valid[i] && in_ready[i] && !clear;
        assign fifo_pop[i]  = load && grant_valid && (grant_id == ID_WIDTH'(i)) && !clear;
        assign sent_now[i]  = out_fire && out_last && (out_id == ID_WIDTH'(i));

        rans_word_fifo #(
            .WIDTH(WORD_WIDTH + 1),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .clr  (clear),
            .push (fifo_push[i]),
            .din  ({in_last[i], in_data[i*WORD_WIDTH +: WORD_WIDTH]}),
            .full (fifo_full[i]),
            .pop  (fifo_pop[i]),
            .dout (fifo_dout[i]),
            .empty(fifo_empty[i])
        );
    end

    // Scan lanes starting at rr_ptr; the index wraps because NUM_STREAMS is 2**ID_WIDTH.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            scan_idx = rr_ptr + ID_WIDTH'(k);
            if (!grant_valid && !fifo_empty[scan_idx]) begin
                grant_valid = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            rr_ptr    <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_entry[WORD_WIDTH-1:0];
                out_last  <= grant_entry[WORD_WIDTH];
                out_id    <= grant_id;
                rr_ptr    <= grant_id + ID_WIDTH'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // all_done folds in this cycle's handshake so it rises right after the final word leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_seen <= '0;
            last_sent <= '0;
            all_done  <= 1'b0;
        end else if (clear) begin
            last_seen <= '0;
            last_sent <= '0;
            all_done  <= 1'b0;
        end else begin
            last_seen <= last_seen | (fifo_push & in_last);
            last_sent <= last_sent | sent_now;
            all_done  <= &(last_sent | sent_now);
        end
    end

endmodule

// File: tb/tb_rans_out_merge.sv
// Self-checking bench for rans_out_merge: directed corner sequences, a
// round-robin vector table and randomized completion runs against a lane-queue model.
module tb_rans_out_merge;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clear = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_last;
    logic           out_ready = 1'b0;
    logic           all_done;

    always #5 clk = ~clk;

    rans_out_merge #(.NUM_STREAMS(N), .WORD_WIDTH(W), .FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_id   (out_id),
        .out_last (out_last),
        .out_ready(out_ready),
        .all_done (all_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue of {last, word} per lane plus delivered-last flags.
    logic [W:0]   exp_q [N][$];
    logic [N-1:0] model_sent = '0;
    logic         model_done = 1'b0;
    int           hs_count = 0;
    logic [W:0]   sb_e;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
            model_sent = '0;
            model_done = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                hs_count++;
                if (exp_q[out_id].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: lane %0d emitted 0x%0h with nothing queued", out_id, out_data);
                end else begin
                    sb_e = exp_q[out_id].pop_front();
                    chk("sb_word", 32'({out_last, out_data}), 32'(sb_e));
                    if (out_last) model_sent[out_id] = 1'b1;
                end
            end
            if (clear) begin
                for (int i = 0; i < N; i++) exp_q[i].delete();
                model_sent = '0;
            end else begin
                for (int i = 0; i < N; i++)
                    if (in_valid[i] && in_ready[i])
                        exp_q[i].push_back({in_last[i], in_data[i*W +: W]});
            end
            model_done = &model_sent;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) chk("all_done", 32'(all_done), 32'(model_done));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] d, input logic l);
        in_data[i*W +: W] = d;
        in_last[i] = l;
    endtask

    task automatic do_clear();
        in_valid = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    typedef struct {
        int         lane;
        logic [W-1:0] word;
        logic [1:0] exp_id;
        logic [W-1:0] exp_word;
    } rr_vec_t;

    rr_vec_t      tbl [8];
    int           acc;
    int           vcount;
    int           cycles;
    int           base;
    int           sent [N];
    logic [N-1:0] rdy_l;

    initial begin
        tbl[0] = '{0, 8'hA0, 2'd0, 8'hA0};
        tbl[1] = '{1, 8'hA1, 2'd1, 8'hA1};
        tbl[2] = '{2, 8'hA2, 2'd2, 8'hA2};
        tbl[3] = '{3, 8'hA3, 2'd3, 8'hA3};
        tbl[4] = '{0, 8'hB0, 2'd0, 8'hB0};
        tbl[5] = '{1, 8'hB1, 2'd1, 8'hB1};
        tbl[6] = '{2, 8'hB2, 2'd2, 8'hB2};
        tbl[7] = '{3, 8'hB3, 2'd3, 8'hB3};

        // Reset state
        #12;
        chk("rst_out", 32'({out_valid, out_id, out_last, out_data}), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_all_done", 32'(all_done), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'hF);

        // Single lane, minimum latency
        out_ready = 1'b1;
        in_valid = 4'b0100;
        set_lane(2, 8'h11, 1'b0);
        tick();
        chk("t1_lat_valid", 32'(out_valid), 0);
        set_lane(2, 8'h22, 1'b0);
        tick();
        chk("t1_w0", 32'({out_valid, out_id, out_last, out_data}), 32'({1'b1, 2'd2, 1'b0, 8'h11}));
        set_lane(2, 8'h33, 1'b1);
        tick();
        in_valid = '0;
        chk("t1_w1", 32'({out_valid, out_id, out_last, out_data}), 32'({1'b1, 2'd2, 1'b0, 8'h22}));
        chk("t1_lane_closed", 32'(in_ready[2]), 0);
        tick();
        chk("t1_w2", 32'({out_valid, out_id, out_last, out_data}), 32'({1'b1, 2'd2, 1'b1, 8'h33}));
        tick();
        chk("t1_idle", 32'(out_valid), 0);
        chk("t1_not_done", 32'(all_done), 0);

        // Round-robin table
        out_ready = 1'b0;
        do_clear();
        for (int k = 0; k < 8; k++) begin
            in_valid[tbl[k].lane] = 1'b1;
            set_lane(tbl[k].lane, tbl[k].word, 1'b0);
            if (k == 3 || k == 7) begin
                tick();
                in_valid = '0;
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t2_rr", 32'({out_valid, out_id, out_data}), 32'({1'b1, tbl[k].exp_id, tbl[k].exp_word}));
            tick();
        end
        chk("t2_empty", 32'(out_valid), 0);

        // Backpressure: 8 buffered plus 1 in the output register
        out_ready = 1'b0;
        do_clear();
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid[0] = 1'b1;
            set_lane(0, W'(8'h40 + acc), 1'b0);
            if (in_ready[0]) acc++;
            tick();
            if (c >= 1) chk("t3_hold", 32'({out_valid, out_id, out_data}), 32'({1'b1, 2'd0, 8'h40}));
        end
        in_valid = '0;
        chk("t3_accepts", 32'(acc), 9);
        chk("t3_ready_low", 32'(in_ready[0]), 0);
        out_ready = 1'b1;
        repeat (12) tick();
        chk("t3_drained", 32'(out_valid), 0);
        chk("t3_no_loss", 32'(exp_q[0].size()), 0);

        // Randomized completion runs
        for (int round = 0; round < 3; round++) begin
            do_clear();
            base = hs_count;
            for (int i = 0; i < N; i++) sent[i] = 0;
            rdy_l = '0;
            cycles = 0;
            while ((hs_count - base) < 5 * N && cycles < 2000) begin
                for (int i = 0; i < N; i++)
                    if (in_valid[i] && rdy_l[i]) begin
                        sent[i]++;
                        in_valid[i] = 1'b0;
                    end
                for (int i = 0; i < N; i++)
                    if (!in_valid[i] && sent[i] < 5 && $urandom_range(0, 2) != 0) begin
                        in_valid[i] = 1'b1;
                        set_lane(i, W'($urandom_range(0, 255)), sent[i] == 4);
                    end
                out_ready = ($urandom_range(0, 3) != 0);
                rdy_l = in_ready;
                tick();
                cycles++;
            end
            in_valid = '0;
            chk("t4_in_time", 32'(cycles < 2000), 1);
            chk("t4_done", 32'(all_done), 1);
            chk("t4_lanes_closed", 32'(in_ready), 0);
            out_ready = 1'b1;
            tick();
            tick();
            chk("t4_done_hold", 32'(all_done), 1);
        end

        // Clear mid-stream with 3 words buffered
        out_ready = 1'b0;
        do_clear();
        for (int k = 0; k < 3; k++) begin
            in_valid = 4'b0010;
            set_lane(1, W'(8'h50 + k), 1'b0);
            tick();
        end
        in_valid = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_ready", 32'(in_ready), 32'hF);
        out_ready = 1'b1;
        vcount = 0;
        repeat (10) begin
            tick();
            if (out_valid) vcount++;
        end
        chk("t5_no_emit", 32'(vcount), 0);

        // Async reset during an output stall
        out_ready = 1'b0;
        in_valid = 4'b1000;
        set_lane(3, 8'h9C, 1'b0);
        tick();
        tick();
        in_valid = '0;
        chk("t6_stalled", 32'({out_valid, out_id, out_data}), 32'({1'b1, 2'd3, 8'h9C}));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_out", 32'({out_valid, out_id, out_last, out_data}), 0);
        chk("t6_async_ready", 32'(in_ready), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("t6_ready_back", 32'(in_ready), 32'hF);
        out_ready = 1'b1;
        in_valid = 4'b0001;
        set_lane(0, 8'h77, 1'b0);
        tick();
        in_valid = '0;
        tick();
        chk("t6_resume", 32'({out_valid, out_id, out_data}), 32'({1'b1, 2'd0, 8'h77}));
        tick();
        chk("t6_idle", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
